// File: rtl/round_sequencer_pkg.sv
// Shared Duck Hunt game-flow types: state encoding, counter widths, and a saturating round increment.
package duck_game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SPAWN     = 3'd1,
        FLY       = 3'd2,
        FALL      = 3'd3,
        ESCAPE    = 3'd4,
        TALLY     = 3'd5,
        GAME_OVER = 3'd6
    } game_state_t;

    localparam int unsigned SHOTS_W    = 2;
    localparam int unsigned DUCK_IDX_W = 4;
    localparam int unsigned HITS_W     = 4;
    localparam int unsigned ROUND_W    = 8;
    localparam int unsigned TICK_W     = 10;

    function automatic logic [ROUND_W-1:0] round_inc(input logic [ROUND_W-1:0] r);
        return (r == '1) ? r : r + 1'b1;
    endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Game-flow bus between the trigger/hit logic (master) and the round sequencer (slave).
interface round_sequencer_if;
    import duck_game_pkg::*;

    logic                  frame_tick;
    logic                  start;
    logic                  shot;
    logic                  hit;
    game_state_t           state;
    logic                  spawn;
    logic [SHOTS_W-1:0]    shots_left;
    logic [DUCK_IDX_W-1:0] duck_idx;
    logic [HITS_W-1:0]     hits;
    logic [ROUND_W-1:0]    round_num;
    logic                  game_over;

    modport master (
        output frame_tick, start, shot, hit,
        input  state, spawn, shots_left, duck_idx, hits, round_num, game_over
    );

    modport slave (
        input  frame_tick, start, shot, hit,
        output state, spawn, shots_left, duck_idx, hits, round_num, game_over
    );

endinterface

// File: rtl/round_sequencer_frame_timer.sv
// Frame-tick counter shared by the FLY, FALL and ESCAPE phases; done while count equals terminal.
module frame_timer
    import duck_game_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              tick,
    input  logic [TICK_W-1:0] terminal,
    output logic              done
);

    logic [TICK_W-1:0] count_q, count_d;

    assign done = (count_q == terminal);

    // Holds at terminal so a stalled phase cannot wrap the count.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick && !done) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/round_sequencer.sv
// Duck Hunt round sequencer: spawn/fly/fall/escape per duck, shot/hit/round accounting, pass/fail tally.
// Optional build macro ROUND_SEQ_UNLIMITED_AMMO_EN: shots never deplete.
module round_sequencer
    import duck_game_pkg::*;
#(
    parameter int unsigned SHOTS_PER_DUCK  = 3,
    parameter int unsigned DUCKS_PER_ROUND = 10,
    parameter int unsigned HITS_TO_PASS    = 6,
    parameter int unsigned FLY_TICKS       = 600,
    parameter int unsigned FALL_TICKS      = 60,
    parameter int unsigned ESCAPE_TICKS    = 90
) (
    input  logic              Clk,
    input  logic              Reset,
    round_sequencer_if.slave  bus
);

`ifdef ROUND_SEQ_UNLIMITED_AMMO_EN
    localparam bit AMMO_LIMITED = 1'b0;
`else
    localparam bit AMMO_LIMITED = 1'b1;
`endif

    localparam logic [SHOTS_W-1:0]    SHOTS_C     = SHOTS_W'(SHOTS_PER_DUCK);
    localparam logic [DUCK_IDX_W-1:0] LAST_DUCK_C = DUCK_IDX_W'(DUCKS_PER_ROUND - 1);
    localparam logic [HITS_W-1:0]     HITS_MAX_C  = HITS_W'(DUCKS_PER_ROUND);
    localparam logic [HITS_W-1:0]     HITS_PASS_C = HITS_W'(HITS_TO_PASS);
    localparam logic [TICK_W-1:0]     FLY_TC      = TICK_W'(FLY_TICKS);
    localparam logic [TICK_W-1:0]     FALL_TC     = TICK_W'(FALL_TICKS);
    localparam logic [TICK_W-1:0]     ESCAPE_TC   = TICK_W'(ESCAPE_TICKS);

    game_state_t           state_q, state_d;
    logic                  spawn_q, spawn_d;
    logic [SHOTS_W-1:0]    shots_left_q, shots_left_d;
    logic [DUCK_IDX_W-1:0] duck_idx_q, duck_idx_d;
    logic [HITS_W-1:0]     hits_q, hits_d;
    logic [ROUND_W-1:0]    round_num_q, round_num_d;
    logic                  game_over_q, game_over_d;
    logic                  shot_q, shot_d;

    logic                  shot_edge;
    logic                  out_of_shots;
    logic                  timer_clear;
    logic                  timer_done;
    logic [TICK_W-1:0]     timer_tc;

    assign shot_edge = bus.shot & ~shot_q;

    always_comb begin
        timer_tc = '0;
        case (state_q)
            FLY:     timer_tc = FLY_TC;
            FALL:    timer_tc = FALL_TC;
            ESCAPE:  timer_tc = ESCAPE_TC;
            default: timer_tc = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        shots_left_d = shots_left_q;
        duck_idx_d   = duck_idx_q;
        hits_d       = hits_q;
        round_num_d  = round_num_q;
        shot_d       = bus.shot;
        out_of_shots = 1'b0;

        case (state_q)
            IDLE, GAME_OVER: begin
                if (bus.start) begin
                    hits_d      = '0;
                    duck_idx_d  = '0;
                    round_num_d = ROUND_W'(1);
                    state_d     = SPAWN;
                end
            end
            SPAWN: begin
                state_d = FLY;
            end
            FLY: begin
                if (AMMO_LIMITED && shot_edge && shots_left_q != '0) begin
                    shots_left_d = shots_left_q - 1'b1;
                    out_of_shots = (shots_left_q == SHOTS_W'(1));
                end
                // A hit outranks both the flight timeout and running out of shots.
                if (bus.hit) begin
                    if (hits_q < HITS_MAX_C) begin
                        hits_d = hits_q + 1'b1;
                    end
                    state_d = FALL;
                end else if (timer_done || out_of_shots) begin
                    state_d = ESCAPE;
                end
            end
            FALL, ESCAPE: begin
                if (timer_done) begin
                    if (duck_idx_q == LAST_DUCK_C) begin
                        state_d = TALLY;
                    end else begin
                        duck_idx_d = duck_idx_q + 1'b1;
                        state_d    = SPAWN;
                    end
                end
            end
            TALLY: begin
                if (hits_q >= HITS_PASS_C) begin
                    round_num_d = round_inc(round_num_q);
                    hits_d      = '0;
                    duck_idx_d  = '0;
                    state_d     = SPAWN;
                end else begin
                    state_d = GAME_OVER;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reload on entry so the SPAWN cycle already shows a full magazine.
        if (state_d == SPAWN) begin
            shots_left_d = SHOTS_C;
        end
    end

    assign spawn_d     = (state_d == SPAWN);
    assign game_over_d = (state_d == GAME_OVER);
    assign timer_clear = (state_d != state_q);

    frame_timer u_frame_timer (
        .clk      (Clk),
        .rst_n    (Reset),
        .clear    (timer_clear),
        .tick     (bus.frame_tick),
        .terminal (timer_tc),
        .done     (timer_done)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            spawn_q      <= 1'b0;
            shots_left_q <= '0;
            duck_idx_q   <= '0;
            hits_q       <= '0;
            round_num_q  <= '0;
            game_over_q  <= 1'b0;
            shot_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            spawn_q      <= spawn_d;
            shots_left_q <= shots_left_d;
            duck_idx_q   <= duck_idx_d;
            hits_q       <= hits_d;
            round_num_q  <= round_num_d;
            game_over_q  <= game_over_d;
            shot_q       <= shot_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.spawn      = spawn_q;
    assign bus.shots_left = shots_left_q;
    assign bus.duck_idx   = duck_idx_q;
    assign bus.hits       = hits_q;
    assign bus.round_num  = round_num_q;
    assign bus.game_over  = game_over_q;

endmodule
